// File: rtl/ddr_cmd_issuer_pkg.sv
// Shared types for the DDR command issuer: bus command encodings, burst sizes,
// per-bank monitor status and the issuer FSM state.
package ddr_cmd_issuer_pkg;

    typedef enum logic [3:0] {
        CMD_MODE_REG_SET = 4'b0000,
        CMD_PRECHARGE    = 4'b0010,
        CMD_ACTIVE       = 4'b0011,
        CMD_WRITE        = 4'b0100,
        CMD_READ         = 4'b0101
    } commands_t;

    typedef logic [3:0] cmd_t;
    localparam cmd_t CMD_DESELECT = 4'b1111;
    localparam cmd_t CMD_NOP      = 4'b0111;

    typedef enum logic [1:0] {
        ONE_BYTE    = 2'd0,
        TWO_BYTES   = 2'd1,
        FOUR_BYTES  = 2'd2,
        EIGHT_BYTES = 2'd3
    } burst_size_t;

    typedef enum logic [1:0] {
        NOT_READY   = 2'd0,
        READ_READY  = 2'd1,
        WRITE_READY = 2'd2,
        FULL_READY  = 2'd3
    } bank_status_t;

    typedef enum logic [2:0] {
        INIT_WAIT   = 3'd0,
        ISSUE_MRS   = 3'd1,
        IDLE        = 3'd2,
        ISSUE_PRE   = 3'd3,
        ISSUE_ACT   = 3'd4,
        ISSUE_RW    = 3'd5,
        GAP         = 3'd6,
        ISSUE_CLOSE = 3'd7
    } issuer_state_t;

    // A bank in READ_READY still refuses writes, and vice versa.
    function automatic logic rw_permitted(input bank_status_t st, input logic is_write);
        logic ok;
        case (st)
            FULL_READY:  ok = 1'b1;
            READ_READY:  ok = ~is_write;
            WRITE_READY: ok = is_write;
            default:     ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/ddr_cmd_issuer_if.sv
// Request handshake, monitor status and DDR command/address bus of the issuer.
// master = requester/monitor side, slave = the issuer.
interface ddr_cmd_issuer_if #(
    parameter int NUM_BANKS = 4,
    parameter int ROW_W     = 13,
    parameter int COL_W     = 10,
    parameter int ADDR_W    = 13
);
    import ddr_cmd_issuer_pkg::*;

    logic               req_valid;
    logic               req_ready;
    logic               req_write;
    logic [1:0]         req_bank;
    logic [ROW_W-1:0]   req_row;
    logic [COL_W-1:0]   req_col;
    burst_size_t        req_burst;
    bank_status_t       bank_status [NUM_BANKS];

    logic               CS;
    logic               RAS;
    logic               CAS;
    logic               WE;
    logic [1:0]         B;
    logic [ADDR_W-1:0]  A;
    burst_size_t        pool_rburst_size;
    burst_size_t        pool_wburst_size;
    logic               init_done;

    modport master (
        output req_valid, req_write, req_bank, req_row, req_col, req_burst, bank_status,
        input  req_ready, CS, RAS, CAS, WE, B, A, pool_rburst_size, pool_wburst_size, init_done
    );

    modport slave (
        input  req_valid, req_write, req_bank, req_row, req_col, req_burst, bank_status,
        output req_ready, CS, RAS, CAS, WE, B, A, pool_rburst_size, pool_wburst_size, init_done
    );

endinterface

// File: rtl/ddr_cmd_issuer_counter.sv
// single_edge_counter: wrapping up-counter whose flag marks the last count
// before rollover, so the caller can act on the edge that completes the period.
module single_edge_counter #(
    parameter int SIZE = 3
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic            clear_i,
    input  logic            count_enable_i,
    input  logic [SIZE-1:0] rollover_val_i,
    output logic            rollover_flag_o
);
    logic [SIZE-1:0] count_q;
    logic [SIZE-1:0] count_d;
    logic [SIZE-1:0] last_s;

    assign last_s          = rollover_val_i - SIZE'(1);
    assign rollover_flag_o = count_enable_i && (count_q == last_s);

    // next count: clear wins, then wrap at the last count
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (count_enable_i) begin
            if (count_q == last_s) begin
                count_d = '0;
            end else begin
                count_d = count_q + SIZE'(1);
            end
        end else begin
            count_d = count_q;
        end
    end

    // count register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/ddr_cmd_issuer.sv
// DDR command issuer: power-up MRS, open-row tracking and status-gated
// PRE/ACT/RD/WR issue. Define DDR_CLOSED_PAGE_EN for a closed-page policy.
module ddr_cmd_issuer
    import ddr_cmd_issuer_pkg::*;
#(
    parameter int               NUM_BANKS   = 4,
    parameter int               ROW_W       = 13,
    parameter int               COL_W       = 10,
    parameter int               ADDR_W      = 13,
    parameter int               INIT_CYCLES = 7,
    parameter logic [ADDR_W-1:0] MODE_REG   = 13'h0032
) (
    input  logic            clk,
    input  logic            n_rst,
    ddr_cmd_issuer_if.slave bus
);
    localparam logic [2:0] INIT_VAL = 3'(INIT_CYCLES);

    issuer_state_t          state_q, state_d;
    issuer_state_t          next_q, next_d;
    cmd_t                   cmd_q, cmd_d;
    logic [1:0]             b_q, b_d;
    logic [ADDR_W-1:0]      a_q, a_d;
    logic                   req_ready_q, req_ready_d;
    logic                   init_done_q, init_done_d;
    burst_size_t            rburst_q, rburst_d;
    burst_size_t            wburst_q, wburst_d;
    logic [NUM_BANKS-1:0]   open_valid_q, open_valid_d;
    logic [ROW_W-1:0]       open_row_q [NUM_BANKS];
    logic [ROW_W-1:0]       open_row_d [NUM_BANKS];
    logic                   cap_write_q, cap_write_d;
    logic [1:0]             cap_bank_q, cap_bank_d;
    logic [ROW_W-1:0]       cap_row_q, cap_row_d;
    logic [COL_W-1:0]       cap_col_q, cap_col_d;
    burst_size_t            cap_burst_q, cap_burst_d;

    logic                   all_ready_s;
    logic                   init_flag_s;
    logic [ADDR_W-1:0]      pre_all_addr_s;

    single_edge_counter #(.SIZE(3)) u_init_cnt (
        .clk             (clk),
        .n_rst           (n_rst),
        .clear_i         (state_q != INIT_WAIT),
        .count_enable_i  (state_q == INIT_WAIT),
        .rollover_val_i  (INIT_VAL),
        .rollover_flag_o (init_flag_s)
    );

    // all-bank precharge carries A[10]=1 and nothing else
    always_comb begin
        pre_all_addr_s     = '0;
        pre_all_addr_s[10] = 1'b1;
    end

    // every bank must be idle for MRS and for precharge-all
    always_comb begin
        all_ready_s = 1'b1;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (bus.bank_status[i] != FULL_READY) begin
                all_ready_s = 1'b0;
            end else begin
                all_ready_s = all_ready_s;
            end
        end
    end

    // FSM next state and registered-output next values
    always_comb begin
        state_d      = state_q;
        next_d       = next_q;
        cmd_d        = CMD_NOP;
        b_d          = b_q;
        a_d          = a_q;
        init_done_d  = init_done_q;
        rburst_d     = rburst_q;
        wburst_d     = wburst_q;
        open_valid_d = open_valid_q;
        open_row_d   = open_row_q;
        cap_write_d  = cap_write_q;
        cap_bank_d   = cap_bank_q;
        cap_row_d    = cap_row_q;
        cap_col_d    = cap_col_q;
        cap_burst_d  = cap_burst_q;

        case (state_q)
            INIT_WAIT: begin
                cmd_d = CMD_DESELECT;
                if (init_flag_s) begin
                    state_d = ISSUE_MRS;
                end else begin
                    state_d = INIT_WAIT;
                end
            end
            ISSUE_MRS: begin
                if (all_ready_s) begin
                    cmd_d       = CMD_MODE_REG_SET;
                    b_d         = 2'd0;
                    a_d         = MODE_REG;
                    init_done_d = 1'b1;
                    state_d     = GAP;
                    next_d      = IDLE;
                end else begin
                    state_d = ISSUE_MRS;
                end
            end
            IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    cap_write_d = bus.req_write;
                    cap_bank_d  = bus.req_bank;
                    cap_row_d   = bus.req_row;
                    cap_col_d   = bus.req_col;
                    cap_burst_d = bus.req_burst;
                    if (open_valid_q[bus.req_bank] && (open_row_q[bus.req_bank] == bus.req_row)) begin
                        state_d = ISSUE_RW;
                    end else if (open_valid_q[bus.req_bank]) begin
                        state_d = ISSUE_PRE;
                    end else begin
                        state_d = ISSUE_ACT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE_PRE, ISSUE_CLOSE: begin
                if (all_ready_s) begin
                    cmd_d        = CMD_PRECHARGE;
                    b_d          = cap_bank_q;
                    a_d          = pre_all_addr_s;
                    open_valid_d = '0;
                    state_d      = GAP;
                    next_d       = (state_q == ISSUE_PRE) ? ISSUE_ACT : IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            ISSUE_ACT: begin
                if (bus.bank_status[cap_bank_q] == FULL_READY) begin
                    cmd_d                    = CMD_ACTIVE;
                    b_d                      = cap_bank_q;
                    a_d                      = ADDR_W'(cap_row_q);
                    open_valid_d[cap_bank_q] = 1'b1;
                    open_row_d[cap_bank_q]   = cap_row_q;
                    state_d                  = GAP;
                    next_d                   = ISSUE_RW;
                end else begin
                    state_d = ISSUE_ACT;
                end
            end
            ISSUE_RW: begin
                if (rw_permitted(bus.bank_status[cap_bank_q], cap_write_q)) begin
                    b_d     = cap_bank_q;
                    a_d     = ADDR_W'(cap_col_q);
                    state_d = GAP;
`ifdef DDR_CLOSED_PAGE_EN
                    next_d  = ISSUE_CLOSE;
`else
                    next_d  = IDLE;
`endif
                    if (cap_write_q) begin
                        cmd_d    = CMD_WRITE;
                        wburst_d = cap_burst_q;
                    end else begin
                        cmd_d    = CMD_READ;
                        rburst_d = cap_burst_q;
                    end
                end else begin
                    state_d = ISSUE_RW;
                end
            end
            GAP: begin
                state_d = next_q;
            end
            default: begin
                cmd_d   = CMD_DESELECT;
                state_d = INIT_WAIT;
            end
        endcase

        req_ready_d = (state_d == IDLE);
    end

    // state, captured request, open-row table and bus registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= INIT_WAIT;
            next_q       <= INIT_WAIT;
            cmd_q        <= CMD_DESELECT;
            b_q          <= 2'd0;
            a_q          <= '0;
            req_ready_q  <= 1'b0;
            init_done_q  <= 1'b0;
            rburst_q     <= ONE_BYTE;
            wburst_q     <= ONE_BYTE;
            open_valid_q <= '0;
            for (int i = 0; i < NUM_BANKS; i++) begin
                open_row_q[i] <= '0;
            end
            cap_write_q  <= 1'b0;
            cap_bank_q   <= 2'd0;
            cap_row_q    <= '0;
            cap_col_q    <= '0;
            cap_burst_q  <= ONE_BYTE;
        end else begin
            state_q      <= state_d;
            next_q       <= next_d;
            cmd_q        <= cmd_d;
            b_q          <= b_d;
            a_q          <= a_d;
            req_ready_q  <= req_ready_d;
            init_done_q  <= init_done_d;
            rburst_q     <= rburst_d;
            wburst_q     <= wburst_d;
            open_valid_q <= open_valid_d;
            open_row_q   <= open_row_d;
            cap_write_q  <= cap_write_d;
            cap_bank_q   <= cap_bank_d;
            cap_row_q    <= cap_row_d;
            cap_col_q    <= cap_col_d;
            cap_burst_q  <= cap_burst_d;
        end
    end

    assign bus.CS               = cmd_q[3];
    assign bus.RAS              = cmd_q[2];
    assign bus.CAS              = cmd_q[1];
    assign bus.WE               = cmd_q[0];
    assign bus.B                = b_q;
    assign bus.A                = a_q;
    assign bus.req_ready        = req_ready_q;
    assign bus.init_done        = init_done_q;
    assign bus.pool_rburst_size = rburst_q;
    assign bus.pool_wburst_size = wburst_q;

endmodule

// File: tb/tb_ddr_cmd_issuer.sv
// Directed bench for ddr_cmd_issuer; expectations follow DDR_CLOSED_PAGE_EN
// when that macro is defined for the build.
module tb_ddr_cmd_issuer;
    import ddr_cmd_issuer_pkg::*;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    ddr_cmd_issuer_if bus ();

    ddr_cmd_issuer dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    function automatic logic [3:0] bus_cmd();
        return {bus.CS, bus.RAS, bus.CAS, bus.WE};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_all_status(input bank_status_t st);
        for (int i = 0; i < 4; i++) bus.bank_status[i] = st;
    endtask

    task automatic release_reset();
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    // offers one request on the accepting edge, then scrambles the fields
    task automatic present_req(input logic wr, input logic [1:0] bank, input logic [12:0] row,
                               input logic [9:0] col, input burst_size_t burst);
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL req_ready_before_accept: got %b need 1", bus.req_ready); end
        bus.req_valid = 1'b1; bus.req_write = wr; bus.req_bank = bank;
        bus.req_row = row; bus.req_col = col; bus.req_burst = burst;
        tick();
        bus.req_valid = 1'b0; bus.req_write = ~wr; bus.req_bank = ~bank;
        bus.req_row = 13'h1fff; bus.req_col = 10'h3ff; bus.req_burst = ONE_BYTE;
        n_cmp++; if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL req_ready_after_accept: got %b need 0", bus.req_ready); end
    endtask

    task automatic test_reset();
        #12;
        n_cmp++; if (bus_cmd() !== 4'b1111) begin n_err++; $display("FAIL reset_cmd: got %b need 1111", bus_cmd()); end
        n_cmp++; if (bus.B !== 2'd0) begin n_err++; $display("FAIL reset_b: got %0d need 0", bus.B); end
        n_cmp++; if (bus.A !== 13'h0000) begin n_err++; $display("FAIL reset_a: got %h need 0000", bus.A); end
        n_cmp++; if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b need 0", bus.req_ready); end
        n_cmp++; if (bus.init_done !== 1'b0) begin n_err++; $display("FAIL reset_init_done: got %b need 0", bus.init_done); end
        n_cmp++; if (bus.pool_rburst_size !== ONE_BYTE) begin n_err++; $display("FAIL reset_rpool: got %0d need 0", bus.pool_rburst_size); end
        n_cmp++; if (bus.pool_wburst_size !== ONE_BYTE) begin n_err++; $display("FAIL reset_wpool: got %0d need 0", bus.pool_wburst_size); end
    endtask

    task automatic test_init_mrs(input string tag);
        release_reset();
        for (int i = 0; i < 7; i++) begin
            tick();
            n_cmp++; if (bus_cmd() !== 4'b1111) begin n_err++; $display("FAIL %s_deselect[%0d]: got %b need 1111", tag, i, bus_cmd()); end
        end
        tick();
        n_cmp++; if (bus_cmd() !== 4'b0000) begin n_err++; $display("FAIL %s_mrs_cmd: got %b need 0000", tag, bus_cmd()); end
        n_cmp++; if (bus.A !== 13'h0032) begin n_err++; $display("FAIL %s_mrs_a: got %h need 0032", tag, bus.A); end
        n_cmp++; if (bus.init_done !== 1'b1) begin n_err++; $display("FAIL %s_init_done: got %b need 1", tag, bus.init_done); end
        n_cmp++; if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL %s_ready_at_mrs: got %b need 0", tag, bus.req_ready); end
        tick();
        n_cmp++; if (bus_cmd() !== 4'b0111) begin n_err++; $display("FAIL %s_gap_nop: got %b need 0111", tag, bus_cmd()); end
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL %s_ready_idle: got %b need 1", tag, bus.req_ready); end
    endtask

    task automatic test_read_miss();
        present_req(1'b0, 2'd2, 13'd5, 10'd3, EIGHT_BYTES);
        tick();
        n_cmp++; if (bus_cmd() !== 4'b0011 || bus.B !== 2'd2 || bus.A !== 13'd5) begin n_err++; $display("FAIL miss_act: got %b B=%0d A=%h need 0011 B=2 A=0005", bus_cmd(), bus.B, bus.A); end
        bus.bank_status[2] = NOT_READY;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (bus_cmd() !== 4'b0111) begin n_err++; $display("FAIL miss_hold_nop[%0d]: got %b need 0111", i, bus_cmd()); end
        end
        n_cmp++; if (bus.pool_rburst_size !== ONE_BYTE) begin n_err++; $display("FAIL miss_rpool_early: got %0d need 0", bus.pool_rburst_size); end
        bus.bank_status[2] = READ_READY;
        tick();
        n_cmp++; if (bus_cmd() !== 4'b0101 || bus.B !== 2'd2 || bus.A !== 13'd3) begin n_err++; $display("FAIL miss_read: got %b B=%0d A=%h need 0101 B=2 A=0003", bus_cmd(), bus.B, bus.A); end
        n_cmp++; if (bus.pool_rburst_size !== EIGHT_BYTES) begin n_err++; $display("FAIL miss_rpool: got %0d need 3", bus.pool_rburst_size); end
        bus.bank_status[2] = FULL_READY;
        tick();
`ifdef DDR_CLOSED_PAGE_EN
        n_cmp++; if (bus_cmd() !== 4'b0111) begin n_err++; $display("FAIL miss_gap: got %b need 0111", bus_cmd()); end
        tick();
        n_cmp++; if (bus_cmd() !== 4'b0010 || bus.A !== 13'h0400) begin n_err++; $display("FAIL miss_close_pre: got %b A=%h need 0010 A=0400", bus_cmd(), bus.A); end
        tick();
`endif
        n_cmp++; if (bus_cmd() !== 4'b0111 || bus.req_ready !== 1'b1) begin n_err++; $display("FAIL miss_tail: got %b ready=%b need 0111 ready=1", bus_cmd(), bus.req_ready); end
        n_cmp++; if (bus.pool_rburst_size !== EIGHT_BYTES) begin n_err++; $display("FAIL miss_rpool_hold: got %0d need 3", bus.pool_rburst_size); end
    endtask

    task automatic test_row_hit();
        present_req(1'b0, 2'd2, 13'd5, 10'd7, TWO_BYTES);
        tick();
`ifdef DDR_CLOSED_PAGE_EN
        n_cmp++; if (bus_cmd() !== 4'b0011 || bus.A !== 13'd5) begin n_err++; $display("FAIL hit_reactivate: got %b A=%h need 0011 A=0005", bus_cmd(), bus.A); end
        tick();
        tick();
`endif
        n_cmp++; if (bus_cmd() !== 4'b0101 || bus.B !== 2'd2 || bus.A !== 13'd7) begin n_err++; $display("FAIL hit_read: got %b B=%0d A=%h need 0101 B=2 A=0007", bus_cmd(), bus.B, bus.A); end
        n_cmp++; if (bus.pool_rburst_size !== TWO_BYTES) begin n_err++; $display("FAIL hit_rpool: got %0d need 1", bus.pool_rburst_size); end
        tick();
`ifdef DDR_CLOSED_PAGE_EN
        n_cmp++; if (bus_cmd() !== 4'b0111) begin n_err++; $display("FAIL hit_gap: got %b need 0111", bus_cmd()); end
        tick();
        n_cmp++; if (bus_cmd() !== 4'b0010 || bus.A !== 13'h0400) begin n_err++; $display("FAIL hit_close_pre: got %b A=%h need 0010 A=0400", bus_cmd(), bus.A); end
        tick();
`endif
        n_cmp++; if (bus_cmd() !== 4'b0111 || bus.req_ready !== 1'b1) begin n_err++; $display("FAIL hit_tail: got %b ready=%b need 0111 ready=1", bus_cmd(), bus.req_ready); end
    endtask

    task automatic test_row_miss();
        logic [3:0] exp_ov;
        present_req(1'b1, 2'd2, 13'd9, 10'd4, FOUR_BYTES);
`ifndef DDR_CLOSED_PAGE_EN
        tick();
        n_cmp++; if (bus_cmd() !== 4'b0010 || bus.B !== 2'd2 || bus.A !== 13'h0400) begin n_err++; $display("FAIL rowmiss_pre: got %b B=%0d A=%h need 0010 B=2 A=0400", bus_cmd(), bus.B, bus.A); end
        tick();
        n_cmp++; if (bus_cmd() !== 4'b0111) begin n_err++; $display("FAIL rowmiss_pre_gap: got %b need 0111", bus_cmd()); end
`endif
        tick();
        n_cmp++; if (bus_cmd() !== 4'b0011 || bus.B !== 2'd2 || bus.A !== 13'd9) begin n_err++; $display("FAIL rowmiss_act: got %b B=%0d A=%h need 0011 B=2 A=0009", bus_cmd(), bus.B, bus.A); end
        tick();
        tick();
        n_cmp++; if (bus_cmd() !== 4'b0100 || bus.B !== 2'd2 || bus.A !== 13'd4) begin n_err++; $display("FAIL rowmiss_write: got %b B=%0d A=%h need 0100 B=2 A=0004", bus_cmd(), bus.B, bus.A); end
        n_cmp++; if (bus.pool_wburst_size !== FOUR_BYTES || bus.pool_rburst_size !== TWO_BYTES) begin n_err++; $display("FAIL rowmiss_pools: got w=%0d r=%0d need w=2 r=1", bus.pool_wburst_size, bus.pool_rburst_size); end
        tick();
`ifdef DDR_CLOSED_PAGE_EN
        exp_ov = 4'b0000;
        tick();
        n_cmp++; if (bus_cmd() !== 4'b0010) begin n_err++; $display("FAIL rowmiss_close_pre: got %b need 0010", bus_cmd()); end
        tick();
`else
        exp_ov = 4'b0100;
`endif
        n_cmp++; if (bus_cmd() !== 4'b0111 || bus.req_ready !== 1'b1) begin n_err++; $display("FAIL rowmiss_tail: got %b ready=%b need 0111 ready=1", bus_cmd(), bus.req_ready); end
        n_cmp++; if (dut.open_valid_q !== exp_ov) begin n_err++; $display("FAIL rowmiss_open_valid: got %b need %b", dut.open_valid_q, exp_ov); end
    endtask

    task automatic test_status_gate();
        present_req(1'b1, 2'd1, 13'd3, 10'd6, EIGHT_BYTES);
        tick();
        n_cmp++; if (bus_cmd() !== 4'b0011 || bus.B !== 2'd1 || bus.A !== 13'd3) begin n_err++; $display("FAIL gate_act: got %b B=%0d A=%h need 0011 B=1 A=0003", bus_cmd(), bus.B, bus.A); end
        bus.bank_status[1] = READ_READY;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (bus_cmd() !== 4'b0111) begin n_err++; $display("FAIL gate_hold_nop[%0d]: got %b need 0111", i, bus_cmd()); end
        end
        bus.bank_status[1] = WRITE_READY;
        tick();
        n_cmp++; if (bus_cmd() !== 4'b0100 || bus.B !== 2'd1 || bus.A !== 13'd6) begin n_err++; $display("FAIL gate_write: got %b B=%0d A=%h need 0100 B=1 A=0006", bus_cmd(), bus.B, bus.A); end
        n_cmp++; if (bus.pool_wburst_size !== EIGHT_BYTES) begin n_err++; $display("FAIL gate_wpool: got %0d need 3", bus.pool_wburst_size); end
        bus.bank_status[1] = FULL_READY;
        tick();
`ifdef DDR_CLOSED_PAGE_EN
        tick();
        n_cmp++; if (bus_cmd() !== 4'b0010) begin n_err++; $display("FAIL gate_close_pre: got %b need 0010", bus_cmd()); end
        tick();
`endif
        n_cmp++; if (bus_cmd() !== 4'b0111 || bus.req_ready !== 1'b1) begin n_err++; $display("FAIL gate_tail: got %b ready=%b need 0111 ready=1", bus_cmd(), bus.req_ready); end
    endtask

    task automatic test_reset_mid();
        bus.bank_status[3] = NOT_READY;
        present_req(1'b0, 2'd3, 13'd1, 10'd2, ONE_BYTE);
        tick();
        tick();
        n_cmp++; if (bus_cmd() !== 4'b0111) begin n_err++; $display("FAIL midrst_wait_nop: got %b need 0111", bus_cmd()); end
        #2 n_rst = 1'b0;
        #1;
        n_cmp++; if (bus_cmd() !== 4'b1111 || bus.B !== 2'd0 || bus.A !== 13'h0000) begin n_err++; $display("FAIL midrst_bus: got %b B=%0d A=%h need 1111 B=0 A=0000", bus_cmd(), bus.B, bus.A); end
        n_cmp++; if (bus.req_ready !== 1'b0 || bus.init_done !== 1'b0) begin n_err++; $display("FAIL midrst_flags: got ready=%b init=%b need 0 0", bus.req_ready, bus.init_done); end
        n_cmp++; if (bus.pool_wburst_size !== ONE_BYTE || bus.pool_rburst_size !== ONE_BYTE) begin n_err++; $display("FAIL midrst_pools: got w=%0d r=%0d need 0 0", bus.pool_wburst_size, bus.pool_rburst_size); end
        n_cmp++; if (dut.open_valid_q !== 4'b0000) begin n_err++; $display("FAIL midrst_open_valid: got %b need 0000", dut.open_valid_q); end
        bus.bank_status[3] = FULL_READY;
        test_init_mrs("reinit");
        present_req(1'b0, 2'd2, 13'd5, 10'd1, ONE_BYTE);
        tick();
        n_cmp++; if (bus_cmd() !== 4'b0011 || bus.A !== 13'd5) begin n_err++; $display("FAIL midrst_reactivate: got %b A=%h need 0011 A=0005", bus_cmd(), bus.A); end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_bank  = 2'd0;
        bus.req_row   = 13'd0;
        bus.req_col   = 10'd0;
        bus.req_burst = ONE_BYTE;
        set_all_status(FULL_READY);
        test_reset();
        test_init_mrs("init");
        test_read_miss();
        test_row_hit();
        test_row_miss();
        test_status_gate();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
